// File: rtl/xoodoo_rc_inv_seq_if.sv
// Handshake bundle for the Xoodoo inverse round-constant sequencer.
// master: start/end_state_in/num_rounds/rc_ready; slave: stream and status outputs.
interface xoodoo_rc_inv_seq_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic [5:0]       end_state_in;
    logic [CNT_W-1:0] num_rounds;
    logic [31:0]      rc_out;
    logic             rc_valid;
    logic             rc_ready;
    logic             rc_last;
    logic             busy;
    logic             done;
    logic [5:0]       cur_state;
    logic             rc_err;

    modport master (
        output start, end_state_in, num_rounds, rc_ready,
        input  rc_out, rc_valid, rc_last, busy, done, cur_state, rc_err
    );

    modport slave (
        input  start, end_state_in, num_rounds, rc_ready,
        output rc_out, rc_valid, rc_last, busy, done, cur_state, rc_err
    );
endinterface

// File: rtl/xoodoo_rc_inv_seq.sv
// Xoodoo inverse round-constant sequencer: walks the RC state backwards from
// the forward end state and streams N constants, last round first.
// Ports: clk, rst (async active-high), bus (slave modport of
// xoodoo_rc_inv_seq_if: start, end_state_in, num_rounds, rc_out, rc_valid,
// rc_ready, rc_last, busy, done, cur_state, rc_err).
// Optional macro XOODOO_RC_INV_CHECK_EN adds START_STATE and the end-state
// check driving rc_err; without it rc_err is tied low.
module xoodoo_rc_inv_seq #(
    parameter int MAX_ROUNDS = 12,
    parameter int CNT_W = 4
`ifdef XOODOO_RC_INV_CHECK_EN
    , parameter logic [5:0] START_STATE = 6'b001_001
`endif
) (
    input  logic clk,
    input  logic rst,
    xoodoo_rc_inv_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        DONE
    } fsm_t;

    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_ROUNDS);

    fsm_t             fsm, fsm_n;
    logic [5:0]       st, st_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] n_req;

    // si: 5*si mod 7 via si + rotl2(si) with end-around carry.
    // qi: multiply by x^-1 in GF(2)[x]/(x^3+x+1).
    function automatic logic [5:0] inv_step(input logic [5:0] s);
        logic [2:0] si;
        logic [2:0] qi;
        logic [2:0] rot;
        logic [3:0] sum;
        logic [2:0] si_n;
        logic [2:0] qi_n;
        si   = s[2:0];
        qi   = s[5:3];
        rot  = {si[0], si[2:1]};
        sum  = {1'b0, si} + {1'b0, rot};
        si_n = sum[2:0] + {2'b00, sum[3]};
        qi_n = {qi[0], qi[2], qi[1] ^ qi[0]};
        return {qi_n, si_n};
    endfunction

    function automatic logic [31:0] rc_fn(input logic [5:0] s);
        logic [31:0] t;
        t = {28'd0, 1'b1, s[5:3]};
        if (s[2:0] == 3'd0 || s[2:0] == 3'd7)
            return 32'd0;
        return t << s[2:0];
    endfunction

    assign n_req = (bus.num_rounds > MAX_N) ? MAX_N : bus.num_rounds;

`ifdef XOODOO_RC_INV_CHECK_EN
    logic err, err_n;
`endif

    always_comb begin
        fsm_n = fsm;
        st_n  = st;
        cnt_n = cnt;
`ifdef XOODOO_RC_INV_CHECK_EN
        err_n = err;
`endif
        unique case (fsm)
            IDLE: begin
                if (bus.start) begin
`ifdef XOODOO_RC_INV_CHECK_EN
                    err_n = 1'b0;
`endif
                    if (n_req == '0) begin
                        fsm_n = DONE;
                    end else begin
                        st_n  = inv_step(bus.end_state_in);
                        cnt_n = n_req - CNT_W'(1);
                        fsm_n = EMIT;
                    end
                end
            end
            EMIT: begin
                if (bus.rc_ready) begin
                    if (cnt != '0) begin
                        st_n  = inv_step(st);
                        cnt_n = cnt - CNT_W'(1);
                    end else begin
                        fsm_n = DONE;
`ifdef XOODOO_RC_INV_CHECK_EN
                        // st has walked back to the forward start state
                        err_n = (st != START_STATE);
`endif
                    end
                end
            end
            DONE: fsm_n = IDLE;
            default: fsm_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm <= IDLE;
            st  <= '0;
            cnt <= '0;
`ifdef XOODOO_RC_INV_CHECK_EN
            err <= 1'b0;
`endif
        end else begin
            fsm <= fsm_n;
            st  <= st_n;
            cnt <= cnt_n;
`ifdef XOODOO_RC_INV_CHECK_EN
            err <= err_n;
`endif
        end
    end

    assign bus.rc_valid  = (fsm == EMIT);
    assign bus.rc_out    = (fsm == EMIT) ? rc_fn(st) : 32'd0;
    assign bus.rc_last   = (fsm == EMIT) && (cnt == '0);
    assign bus.busy      = (fsm != IDLE);
    assign bus.done      = (fsm == DONE);
    assign bus.cur_state = st;
`ifdef XOODOO_RC_INV_CHECK_EN
    assign bus.rc_err    = err;
`else
    assign bus.rc_err    = 1'b0;
`endif

endmodule

// File: tb/tb_xoodoo_rc_inv_seq.sv
// Self-checking bench for xoodoo_rc_inv_seq: vector table, hand sequences
// and randomized runs against a GF/modular-arithmetic reference model.
module tb_xoodoo_rc_inv_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    xoodoo_rc_inv_seq_if #(.CNT_W(4)) ifc ();

    xoodoo_rc_inv_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    // ---------------- reference model ----------------
    function automatic logic [2:0] gf8_mul(input logic [2:0] a, input logic [2:0] b);
        logic [4:0] p;
        p = '0;
        for (int i = 0; i < 3; i++)
            if (b[i]) p = p ^ (5'({2'b00, a}) << i);
        for (int i = 4; i >= 3; i--)
            if (p[i]) p = p ^ (5'b01011 << (i - 3));
        return p[2:0];
    endfunction

    function automatic logic [5:0] m_inv(input logic [5:0] s);
        int si;
        logic [2:0] qn;
        si = int'(s[2:0]);
        if (si != 0 && si != 7) si = (5 * si) % 7;
        // x^-1 = x^2 + 1 in GF(8) with x^3+x+1
        qn = gf8_mul(s[5:3], 3'd5);
        return {qn, 3'(si)};
    endfunction

    function automatic logic [31:0] m_rc(input logic [5:0] s);
        int si;
        si = int'(s[2:0]);
        if (si == 0 || si == 7) return 32'd0;
        return (32'd8 + 32'(s[5:3])) * (32'd1 << si);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One full run; checks every beat against the model and reports summary.
    task automatic run(input logic [5:0] es, input logic [3:0] nr,
                       input int sb, input int sl, input bit rnd, input int inj,
                       output logic [31:0] first, output logic [5:0] fin,
                       output int beats, output int busy_cyc);
        int n;
        int idx;
        int stalls;
        bit seen_done;
        bit rdy;
        logic exp_err;
        logic [5:0] s;
        logic [31:0] q_rc[$];
        logic [5:0]  q_st[$];
        n = (nr > 4'd12) ? 12 : int'(nr);
        s = es;
        for (int k = 0; k < n; k++) begin
            s = m_inv(s);
            q_st.push_back(s);
            q_rc.push_back(m_rc(s));
        end
`ifdef XOODOO_RC_INV_CHECK_EN
        exp_err = (n != 0) && (s != 6'h09);
`else
        exp_err = 1'b0;
`endif
        first = '0;
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.end_state_in = es;
        ifc.num_rounds = nr;
        @(negedge clk);
        ifc.start = 1'b0;
        chk("err_clear", 32'(ifc.rc_err), 32'd0);
        idx = 0;
        stalls = 0;
        busy_cyc = 0;
        seen_done = 1'b0;
        for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            ifc.start = (cyc == inj);
            if (cyc == inj) begin
                ifc.end_state_in = 6'h2B;
                ifc.num_rounds = 4'd5;
            end
            if (ifc.busy) busy_cyc++;
            if (ifc.rc_valid) begin
                if (idx >= n) begin
                    chk("extra_beat", 32'(idx), 32'(n - 1));
                end else begin
                    chk("rc_out", ifc.rc_out, q_rc[idx]);
                    chk("rc_last", 32'(ifc.rc_last), 32'(idx == n - 1));
                    chk("state", 32'(ifc.cur_state), 32'(q_st[idx]));
                    if (idx == 0) first = ifc.rc_out;
                end
                rdy = rnd ? ($urandom_range(0, 3) != 0) : !(idx == sb && stalls < sl);
                if (!rdy) stalls++;
                else idx++;
                ifc.rc_ready = rdy;
            end else begin
                chk("rc_zero", ifc.rc_out, 32'd0);
                ifc.rc_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (ifc.done) begin
                seen_done = 1'b1;
                chk("beats", 32'(idx), 32'(n));
                chk("rc_err", 32'(ifc.rc_err), 32'(exp_err));
            end
        end
        ifc.start = 1'b0;
        if (!seen_done) chk("timeout", 32'd0, 32'd1);
        chk("busy_len", 32'(busy_cyc), 32'(n + 1 + stalls));
        @(negedge clk);
        chk("idle_after", {30'd0, ifc.done, ifc.busy}, 32'd0);
        chk("err_sticky", 32'(ifc.rc_err), 32'(exp_err));
        if (n > 0) chk("fin_state", 32'(ifc.cur_state), 32'(s));
        fin = ifc.cur_state;
        beats = idx;
    endtask

    typedef struct {
        logic [5:0]  es;
        logic [3:0]  nr;
        int          sb;
        int          sl;
        int          inj;
        int          beats;
        logic [31:0] first;
        logic [5:0]  fin;
        int          busy;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [31:0] first;
        logic [5:0]  fin;
        int beats;
        int busy_cyc;

        tbl[0] = '{6'h1E, 4'd3,  -1, 0, -1,  3, 32'h30, 6'h09,  4};
        tbl[1] = '{6'h1E, 4'd3,   1, 3, -1,  3, 32'h30, 6'h09,  7};
        tbl[2] = '{6'h1E, 4'd0,  -1, 0, -1,  0, 32'h0,  6'h00,  1};
        tbl[3] = '{6'h1E, 4'd15, -1, 0, -1, 12, 32'h30, 6'h3E, 13};
        tbl[4] = '{6'h08, 4'd4,  -1, 0, -1,  4, 32'h0,  6'h18,  5};
        tbl[5] = '{6'h1E, 4'd2,  -1, 0, -1,  2, 32'h30, 6'h13,  3};
        tbl[6] = '{6'h1E, 4'd3,  -1, 0,  1,  3, 32'h30, 6'h09,  4};

        ifc.start = 1'b0;
        ifc.end_state_in = '0;
        ifc.num_rounds = '0;
        ifc.rc_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_outs", {ifc.rc_valid, ifc.busy, ifc.done, ifc.rc_last, ifc.rc_err,
                         27'd0} | ifc.rc_out, 32'd0);
        chk("rst_state", 32'(ifc.cur_state), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle", {29'd0, ifc.rc_valid, ifc.busy, ifc.done}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            run(tbl[i].es, tbl[i].nr, tbl[i].sb, tbl[i].sl, 1'b0, tbl[i].inj,
                first, fin, beats, busy_cyc);
            chk($sformatf("t%0d_beats", i), 32'(beats), 32'(tbl[i].beats));
            chk($sformatf("t%0d_busy", i), 32'(busy_cyc), 32'(tbl[i].busy));
            if (tbl[i].beats > 0) begin
                chk($sformatf("t%0d_first", i), first, tbl[i].first);
                chk($sformatf("t%0d_fin", i), 32'(fin), 32'(tbl[i].fin));
            end
        end

        // reset after the first beat has been accepted
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.end_state_in = 6'h1E;
        ifc.num_rounds = 4'd3;
        ifc.rc_ready = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        chk("mr_beat0", ifc.rc_out, 32'h30);
        @(negedge clk);
        chk("mr_beat1", ifc.rc_out, 32'h50);
        rst = 1'b1;
        #1;
        chk("mr_outs", {ifc.rc_valid, ifc.busy, ifc.done, ifc.rc_last, 28'd0} | ifc.rc_out,
            32'd0);
        chk("mr_state", 32'(ifc.cur_state), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mr_nodone", {30'd0, ifc.done, ifc.busy}, 32'd0);
        end
        run(6'h1E, 4'd3, -1, 0, 1'b0, -1, first, fin, beats, busy_cyc);
        chk("mr_rerun_first", first, 32'h30);
        chk("mr_rerun_fin", 32'(fin), 32'h09);

        for (int r = 0; r < 25; r++) begin
            run(6'($urandom), 4'($urandom), -1, 0, 1'b1, -1, first, fin, beats, busy_cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/xoodoo_rc_inv_seq.md
Name: xoodoo_rc_inv_seq

Overview:
Sequential inverse round-constant generator for the Xoodoo inverse permutation. It is loaded with the RC state reached after N forward steps. It walks the RC state machine backwards and streams the N round constants in reverse order (last round first) over a valid/ready interface. It sits beside the inverse-permutation datapath and is the counterpart of the forward per-round RC stepper.

Parameters:
MAX_ROUNDS, 12, upper bound on rounds per run; larger num_rounds requests are clamped to this value.
CNT_W, 4, width of num_rounds and of the internal round counter; must satisfy 2^CNT_W > MAX_ROUNDS.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; accepted only when busy=0
end_state_in  in  6  [2:0]=si, [5:3]=qi; forward RC state after N steps; sampled on accepted start
num_rounds  in  CNT_W  N, number of constants to emit; sampled on accepted start
rc_out  out  32  round constant; zero when rc_valid=0
rc_valid  out  1  rc_out is valid
rc_ready  in  1  consumer accepts rc_out
rc_last  out  1  current rc_out is the final (round-0) constant
busy  out  1  run in progress (from accepted start through the done cycle)
done  out  1  one-cycle pulse after the last constant has been accepted
cur_state  out  6  current internal RC state register
rc_err  out  1  start-state check failure, sticky until the next accepted start (see Optional Feature)

Behaviour:
- Reset (asynchronous, any time, including mid-run): FSM=IDLE; state=0; cnt=0; all outputs 0. Any run in flight is abandoned with no done pulse.
- Inverse step on state {qi,si}:
  - si' = si + rotl2(si) over 4 bits, with end-around carry folded into 3 bits. This equals 5*si mod 7. si=0 maps to 0 and si=7 maps to 7.
  - qi'[0]=qi[1]^qi[0]; qi'[1]=qi[2]; qi'[2]=qi[0]. This is multiplication by x^-1 mod x^3+x+1.
- RC function of state {qi,si}:
  - t = {1,qi}, 4 bits.
  - For si in 1..6: rc = t << si, zero-extended to 32 bits.
  - For si = 0 or 7: rc = 0.
- FSM states: IDLE, EMIT, DONE.
- IDLE, accepted start with N = min(num_rounds, MAX_ROUNDS):
  - If N=0: go to DONE. No constant is emitted.
  - If N>0: state <= inv(end_state_in); cnt <= N-1; go to EMIT.
  - busy=1 from the cycle after start.
- EMIT:
  - rc_valid=1; rc_out=rc(state); rc_last=(cnt==0).
  - When rc_valid & rc_ready and cnt!=0: state <= inv(state); cnt <= cnt-1; stay in EMIT.
  - When rc_valid & rc_ready and cnt==0: go to DONE. state holds, and equals the original forward start state.
- Backpressure: while rc_valid & !rc_ready, rc_out, rc_last and state are held stable.
- DONE: done=1 for exactly one cycle, busy=1; then IDLE with busy=0.
- start is ignored whenever busy=1.
- Latency and throughput: first rc_valid one cycle after the accepted start. One constant per cycle under continuous rc_ready. A run with N constants and no stalls occupies N+1 cycles of busy.

Optional Feature:
Macro XOODOO_RC_INV_CHECK_EN.
- Defined:
  - Parameter START_STATE (6 bits, default 6'b001_001) is added.
  - On entry to DONE, rc_err <= (state != START_STATE). This check is skipped when N=0.
  - rc_err is cleared on an accepted start or reset.
- Not defined: rc_err is tied to 0 and no compare logic is generated.

Test Plan:
- Reset then idle: rst pulse, no start -> rc_valid=0, busy=0, done=0, rc_out=0, cur_state=0.
- Nominal reverse run: end_state_in=6'h1E, num_rounds=3, rc_ready=1 -> constants 0x2C0 (round 3) are not emitted; the stream is rc_out=0x030, 0x050, 0x012 on consecutive cycles starting one cycle after start. rc_last is set only on 0x012, done pulses the next cycle, and cur_state ends at 6'h09 (rc_err=0 with the check enabled).
- Backpressure: same run with rc_ready low for 3 cycles on the second beat -> 0x050 is held stable for those cycles, the sequence is unchanged, and busy is extended by 3 cycles.
- Boundaries: num_rounds=0 -> no rc_valid, done pulses one cycle after start. num_rounds=15 -> exactly 12 constants. end_state_in with si=0 -> rc_out=0 every beat, and state stays si=0.
- Start while busy, and reset mid-run: a start pulse during EMIT is ignored and does not reload. rst asserted after the first beat -> all outputs 0 immediately, no done; a subsequent start runs cleanly.
- Check feature (XOODOO_RC_INV_CHECK_EN defined): end_state_in=6'h1E with N=2 -> the run ends at state 6'h13, so rc_err=1. The next start with N=3 clears rc_err, and it remains 0 at that run's end.
